// File: rtl/screen_ctl_if.sv
// Purpose: bundles the screen controller's mouse, frame-sync, video-source
//          and theme signals so a single port carries the whole video/menu bus.
// Ports:   master = environment side (drives mouse/back/vsync/sources, reads
//          selected video + state); slave = controller side (the reverse).
interface screen_ctl_if #(
  parameter int NUM_SCREENS = 4,
  parameter int NUM_LEVELS  = 2,
  parameter int NUM_THEMES  = 7,
  parameter int COLOR_W     = 12
);
  localparam int SCR_W = $clog2(NUM_SCREENS);
  localparam int LVL_W = $clog2((NUM_LEVELS > 2) ? NUM_LEVELS : 2);
  localparam int THM_W = $clog2((NUM_THEMES > 2) ? NUM_THEMES : 2);

  // Menu / navigation inputs
  logic                           mouse_left;
  logic [11:0]                    xpos;
  logic [11:0]                    ypos;
  logic                           back;
  logic                           vsync_in;

  // Pre-rendered video sources, one slice per screen
  logic [NUM_SCREENS*COLOR_W-1:0] src_rgb;
  logic [NUM_SCREENS-1:0]         src_hsync;
  logic [NUM_SCREENS-1:0]         src_vsync;

  // Selected video and controller state
  logic [COLOR_W-1:0]             rgb_out;
  logic                           hsync_out;
  logic                           vsync_out;
  logic [SCR_W-1:0]               screen;
  logic [LVL_W-1:0]               level;
  logic [THM_W-1:0]               theme;
  logic [COLOR_W-1:0]             color1;
  logic [COLOR_W-1:0]             color2;

  modport master (
    output mouse_left, xpos, ypos, back, vsync_in,
    output src_rgb, src_hsync, src_vsync,
    input  rgb_out, hsync_out, vsync_out,
    input  screen, level, theme, color1, color2
  );

  modport slave (
    input  mouse_left, xpos, ypos, back, vsync_in,
    input  src_rgb, src_hsync, src_vsync,
    output rgb_out, hsync_out, vsync_out,
    output screen, level, theme, color1, color2
  );
endinterface

// File: rtl/screen_ctl.sv
// Purpose: Pong top-level screen controller. Picks one of NUM_SCREENS
//          pre-rendered video sources (screen 0 = menu), decodes menu clicks
//          into navigation / level-cycle / theme-cycle actions, commits
//          screen switches only on a rising frame vsync, and drives the
//          shared colour theme (fg = color1, bg = color2) to all renderers.
// Latency: video mux is one registered stage; level/theme change the cycle
//          after the click; screen changes on the vs_rise cycle.
// Ports:   clk, rst (synchronous, active-high) plus the screen_ctl_if slave
//          modport carrying mouse, back, vsync_in, sources and all outputs.
module screen_ctl #(
  parameter int NUM_SCREENS = 4,
  parameter int NUM_LEVELS  = 2,
  parameter int NUM_THEMES  = 7,
  parameter int COLOR_W     = 12,
  parameter int BTN_X0      = 362,
  parameter int BTN_X1      = 674,
  parameter int BTN_Y0      = 46,
  parameter int BTN_PITCH   = 192,
  parameter int BTN_H       = 100,
  // Theme t: fg at [2t*COLOR_W +: COLOR_W], bg directly above it.
  parameter logic [2*NUM_THEMES*COLOR_W-1:0] PALETTE = {
    12'hF6F, 12'h393,   // theme 6
    12'h6FF, 12'h933,   // theme 5
    12'hFF6, 12'h339,   // theme 4
    12'h66F, 12'h990,   // theme 3
    12'h6F6, 12'h909,   // theme 2
    12'hF66, 12'h099,   // theme 1
    12'hFFF, 12'h000    // theme 0
  }
) (
  input  logic         clk,
  input  logic         rst,
  screen_ctl_if.slave  bus
);

  localparam int SCR_W = $clog2(NUM_SCREENS);
  localparam int LVL_W = $clog2((NUM_LEVELS > 2) ? NUM_LEVELS : 2);
  localparam int THM_W = $clog2((NUM_THEMES > 2) ? NUM_THEMES : 2);

  // Button index needs to cover 0..NUM_SCREENS (up to 8).
  localparam int BTN_W = 4;

  localparam logic [BTN_W-1:0] BTN_LAST_NAV = BTN_W'(NUM_SCREENS - 2);
  localparam logic [BTN_W-1:0] BTN_LEVEL    = BTN_W'(NUM_SCREENS - 1);
  localparam logic [BTN_W-1:0] BTN_THEME    = BTN_W'(NUM_SCREENS);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic               mouse_q,  mouse_d;
  logic               vs_q,     vs_d;
  logic [SCR_W-1:0]   screen_q, screen_d;
  logic               pend_vld_q, pend_vld_d;
  logic [SCR_W-1:0]   pend_idx_q, pend_idx_d;
  logic [LVL_W-1:0]   level_q,  level_d;
  logic [THM_W-1:0]   theme_q,  theme_d;
  logic [COLOR_W-1:0] rgb_q,    rgb_d;
  logic               hs_q,     hs_d;
  logic               vso_q,    vso_d;

  // ---------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------
  logic click;
  logic vs_rise;

  assign click   = bus.mouse_left & ~mouse_q;
  assign vs_rise = bus.vsync_in & ~vs_q;

  // ---------------------------------------------------------------------
  // Hit test: all buttons share the same x span and are stacked in y with
  // a fixed pitch. Pitch exceeds height, so at most one button can match.
  // ---------------------------------------------------------------------
  logic [31:0]      x_w;
  logic [31:0]      y_w;
  logic             hit_vld;
  logic [BTN_W-1:0] hit_idx;

  assign x_w = {20'd0, bus.xpos};
  assign y_w = {20'd0, bus.ypos};

  always_comb begin
    hit_vld = 1'b0;
    hit_idx = '0;
    if (x_w >= 32'(BTN_X0) && x_w <= 32'(BTN_X1)) begin
      for (int k = 0; k <= NUM_SCREENS; k++) begin
        if (!hit_vld &&
            y_w >= 32'(BTN_Y0 + k * BTN_PITCH) &&
            y_w <= 32'(BTN_Y0 + k * BTN_PITCH + BTN_H)) begin
          hit_vld = 1'b1;
          hit_idx = BTN_W'(k);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Action decode. Menu buttons only act while the menu is the committed
  // screen; back only acts away from the menu, so the two request sources
  // are mutually exclusive.
  // ---------------------------------------------------------------------
  logic             menu_click;
  logic             nav_req;
  logic             lvl_req;
  logic             thm_req;
  logic             back_req;
  logic             req_vld;
  logic [SCR_W-1:0] req_idx;

  assign menu_click = click & hit_vld & (screen_q == '0);
  assign nav_req    = menu_click & (hit_idx <= BTN_LAST_NAV);
  assign lvl_req    = menu_click & (hit_idx == BTN_LEVEL);
  assign thm_req    = menu_click & (hit_idx == BTN_THEME);
  assign back_req   = bus.back & (screen_q != '0);

  assign req_vld = nav_req | back_req;
  assign req_idx = nav_req ? SCR_W'(hit_idx + BTN_W'(1)) : '0;

  // ---------------------------------------------------------------------
  // Level / theme cycling with wrap. A single-entry range holds at 0.
  // ---------------------------------------------------------------------
  always_comb begin
    level_d = level_q;
    if (lvl_req) begin
      if (NUM_LEVELS == 1 || level_q == LVL_W'(NUM_LEVELS - 1)) begin
        level_d = '0;
      end else begin
        level_d = level_q + LVL_W'(1);
      end
    end
  end

  always_comb begin
    theme_d = theme_q;
    if (thm_req) begin
      if (NUM_THEMES == 1 || theme_q == THM_W'(NUM_THEMES - 1)) begin
        theme_d = '0;
      end else begin
        theme_d = theme_q + THM_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Pending switch and frame-boundary commit.
  // On vs_rise an existing pending entry commits first; a request arriving
  // in that same cycle becomes the new pending entry for the next frame.
  // Without an existing entry a same-cycle request is only captured, so it
  // waits for the following vs_rise.
  // ---------------------------------------------------------------------
  always_comb begin
    screen_d   = screen_q;
    pend_vld_d = pend_vld_q;
    pend_idx_d = pend_idx_q;
    if (vs_rise && pend_vld_q) begin
      screen_d   = pend_idx_q;
      pend_vld_d = 1'b0;
    end
    if (req_vld) begin
      pend_vld_d = 1'b1;
      pend_idx_d = req_idx;
    end
  end

  // ---------------------------------------------------------------------
  // Video mux, driven by the registered screen so a switch shows up the
  // cycle after it commits.
  // ---------------------------------------------------------------------
  always_comb begin
    rgb_d = bus.src_rgb[int'(screen_q) * COLOR_W +: COLOR_W];
    hs_d  = bus.src_hsync[screen_q];
    vso_d = bus.src_vsync[screen_q];
  end

  assign mouse_d = bus.mouse_left;
  assign vs_d    = bus.vsync_in;

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mouse_q    <= 1'b0;
      vs_q       <= 1'b0;
      screen_q   <= '0;
      pend_vld_q <= 1'b0;
      pend_idx_q <= '0;
      level_q    <= '0;
      theme_q    <= '0;
      rgb_q      <= '0;
      hs_q       <= 1'b0;
      vso_q      <= 1'b0;
    end else begin
      mouse_q    <= mouse_d;
      vs_q       <= vs_d;
      screen_q   <= screen_d;
      pend_vld_q <= pend_vld_d;
      pend_idx_q <= pend_idx_d;
      level_q    <= level_d;
      theme_q    <= theme_d;
      rgb_q      <= rgb_d;
      hs_q       <= hs_d;
      vso_q      <= vso_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs. Palette colours follow the theme register combinationally.
  // ---------------------------------------------------------------------
  assign bus.rgb_out   = rgb_q;
  assign bus.hsync_out = hs_q;
  assign bus.vsync_out = vso_q;
  assign bus.screen    = screen_q;
  assign bus.level     = level_q;
  assign bus.theme     = theme_q;
  assign bus.color1    = PALETTE[(2 * int'(theme_q)) * COLOR_W +: COLOR_W];
  assign bus.color2    = PALETTE[(2 * int'(theme_q) + 1) * COLOR_W +: COLOR_W];

endmodule

// File: tb/tb_screen_ctl.sv
// Purpose: self-checking bench for screen_ctl: directed menu/navigation
//          scenarios with literal expectations, then randomized traffic
//          compared every cycle against a behavioural model.
module tb_screen_ctl;

  localparam int NS = 4;
  localparam int NL = 2;
  localparam int NT = 7;
  localparam int CW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  screen_ctl_if #(.NUM_SCREENS(NS), .NUM_LEVELS(NL), .NUM_THEMES(NT), .COLOR_W(CW)) sif ();

  screen_ctl #(.NUM_SCREENS(NS), .NUM_LEVELS(NL), .NUM_THEMES(NT), .COLOR_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Theme palette as plain tables
  int pal_fg [NT] = '{'h000, 'h099, 'h909, 'h990, 'h339, 'h933, 'h393};
  int pal_bg [NT] = '{'hFFF, 'hF66, 'h6F6, 'h66F, 'hFF6, 'h6FF, 'hF6F};

  // ------------------------------------------------------------------
  // Behavioural model
  // ------------------------------------------------------------------
  int m_screen, m_level, m_theme, m_pend;   // m_pend = -1 when nothing pending
  int m_rgb, m_hs, m_vs;
  bit m_prev_mouse, m_prev_vs;

  // Button index from coordinates by division; -1 when no button is hit.
  function automatic int hit(int x, int y);
    int k;
    if (x < 362 || x > 674 || y < 46) return -1;
    k = (y - 46) / 192;
    if ((y - 46) % 192 > 100) return -1;
    if (k > NS) return -1;
    return k;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_screen = 0; m_level = 0; m_theme = 0; m_pend = -1;
      m_rgb = 0; m_hs = 0; m_vs = 0;
      m_prev_mouse = 0; m_prev_vs = 0;
    end else begin
      int old, req, b;
      old   = m_screen;
      m_rgb = int'(sif.src_rgb[old*CW +: CW]);
      m_hs  = int'(sif.src_hsync[old]);
      m_vs  = int'(sif.src_vsync[old]);
      req   = -1;
      if (sif.mouse_left && !m_prev_mouse && old == 0) begin
        b = hit(int'(sif.xpos), int'(sif.ypos));
        if (b >= 0 && b <= NS - 2)  req = b + 1;
        else if (b == NS - 1)       m_level = (m_level + 1) % NL;
        else if (b == NS)           m_theme = (m_theme + 1) % NT;
      end
      if (sif.back && old != 0) req = 0;
      if (sif.vsync_in && !m_prev_vs && m_pend >= 0) begin
        m_screen = m_pend;
        m_pend   = -1;
      end
      if (req >= 0) m_pend = req;
      m_prev_mouse = sif.mouse_left;
      m_prev_vs    = sif.vsync_in;
    end
  end

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("screen",    32'(sif.screen),    32'(m_screen));
      cmp("level",     32'(sif.level),     32'(m_level));
      cmp("theme",     32'(sif.theme),     32'(m_theme));
      cmp("color1",    32'(sif.color1),    32'(pal_fg[m_theme]));
      cmp("color2",    32'(sif.color2),    32'(pal_bg[m_theme]));
      cmp("rgb_out",   32'(sif.rgb_out),   32'(m_rgb));
      cmp("hsync_out", 32'(sif.hsync_out), 32'(m_hs));
      cmp("vsync_out", 32'(sif.vsync_out), 32'(m_vs));
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers (inputs change just after the falling edge)
  // ------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic press(int x, int y);
    sif.xpos = 12'(x);
    sif.ypos = 12'(y);
    sif.mouse_left = 1'b1;
    tick();
    sif.mouse_left = 1'b0;
    repeat (2) tick();
  endtask

  task automatic vs_pulse();
    sif.vsync_in = 1'b1;
    repeat (3) tick();
    sif.vsync_in = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pulse_back();
    sif.back = 1'b1;
    tick();
    sif.back = 1'b0;
    tick();
  endtask

  initial begin
    sif.mouse_left = 1'b0;
    sif.xpos       = '0;
    sif.ypos       = '0;
    sif.back       = 1'b0;
    sif.vsync_in   = 1'b0;
    sif.src_rgb    = 48'hDDD_CCC_BBB_AAA;
    sif.src_hsync  = 4'b0101;
    sif.src_vsync  = 4'b0011;
    rst = 1'b1;
    repeat (2) tick();
    chk_en = 1'b1;
    rst = 1'b0;

    // Model hit-test pinned by hand
    cmp("hit_b0",   32'(hit(400, 100)), 32'(0));
    cmp("hit_b3",   32'(hit(400, 700)), 32'(3));
    cmp("hit_b4",   32'(hit(400, 814)), 32'(4));
    cmp("hit_miss", 32'(hit(300, 100)), 32'(-1));
    cmp("hit_gap",  32'(hit(400, 147)), 32'(-1));

    // Idle after reset
    repeat (2) tick();
    cmp("rst_screen", 32'(sif.screen), 32'(0));
    cmp("rst_c1",     32'(sif.color1), 32'h000);
    cmp("rst_c2",     32'(sif.color2), 32'hFFF);
    cmp("idle_rgb",   32'(sif.rgb_out), 32'hAAA);

    // Theme cycling: seven presses
    for (int i = 1; i <= 7; i++) begin
      press(400, 814);
      cmp("theme_cyc", 32'(sif.theme), 32'(i % 7));
      if (i == 1) begin
        cmp("theme1_c1", 32'(sif.color1), 32'h099);
        cmp("theme1_c2", 32'(sif.color2), 32'hF66);
      end
    end

    // Level button held for a long time: one step only, then wrap
    sif.xpos = 12'd400;
    sif.ypos = 12'd700;
    sif.mouse_left = 1'b1;
    repeat (1000) tick();
    cmp("level_hold", 32'(sif.level), 32'(1));
    sif.mouse_left = 1'b0;
    tick();
    press(400, 700);
    cmp("level_wrap", 32'(sif.level), 32'(0));

    // Navigate to screen 1, committed on vs_rise 50 cycles later
    press(400, 100);
    repeat (50) tick();
    cmp("nav_wait", 32'(sif.screen), 32'(0));
    sif.vsync_in = 1'b1;
    tick();
    cmp("nav_commit", 32'(sif.screen), 32'(1));
    tick();
    cmp("nav_rgb", 32'(sif.rgb_out), 32'hBBB);
    sif.vsync_in = 1'b0;
    tick();

    // Back to menu, then to screen 2, then back again
    pulse_back();
    repeat (5) tick();
    cmp("back_wait1", 32'(sif.screen), 32'(1));
    vs_pulse();
    cmp("back_done1", 32'(sif.screen), 32'(0));
    press(400, 248);
    vs_pulse();
    cmp("nav2", 32'(sif.screen), 32'(2));
    pulse_back();
    cmp("back_wait2", 32'(sif.screen), 32'(2));
    vs_pulse();
    cmp("back_done2", 32'(sif.screen), 32'(0));
    pulse_back();
    vs_pulse();
    cmp("back_menu", 32'(sif.screen), 32'(0));

    // Click on button 1 coincident with vs_rise, screen 1 already pending
    press(400, 100);
    sif.xpos = 12'd400;
    sif.ypos = 12'd248;
    sif.mouse_left = 1'b1;
    sif.vsync_in   = 1'b1;
    tick();
    cmp("simul_first", 32'(sif.screen), 32'(1));
    sif.mouse_left = 1'b0;
    sif.vsync_in   = 1'b0;
    repeat (3) tick();
    cmp("simul_hold", 32'(sif.screen), 32'(1));
    vs_pulse();
    cmp("simul_second", 32'(sif.screen), 32'(2));

    // Reset discards a pending switch
    pulse_back();
    vs_pulse();
    press(400, 440);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    vs_pulse();
    cmp("rst_pending", 32'(sif.screen), 32'(0));

    // Randomized traffic
    for (int c = 0; c < 6000; c++) begin
      int k, off;
      k   = $urandom_range(0, 5);
      off = $urandom_range(0, 4);
      case (off)
        0: off = -1;
        1: off = 0;
        2: off = 50;
        3: off = 100;
        default: off = 101;
      endcase
      case ($urandom_range(0, 4))
        0: sif.xpos = 12'd361;
        1: sif.xpos = 12'd362;
        2: sif.xpos = 12'd674;
        3: sif.xpos = 12'd675;
        default: sif.xpos = 12'($urandom_range(362, 674));
      endcase
      sif.ypos = 12'(46 + k * 192 + off);
      if ($urandom_range(0, 3) == 0) sif.mouse_left = ~sif.mouse_left;
      if ($urandom_range(0, 7) == 0) sif.vsync_in   = ~sif.vsync_in;
      sif.back      = ($urandom_range(0, 19) == 0);
      sif.src_rgb   = 48'({$urandom(), $urandom()});
      sif.src_hsync = 4'($urandom());
      sif.src_vsync = 4'($urandom());
      rst           = ($urandom_range(0, 699) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/screen_ctl.md
Name: screen_ctl

Overview:
- Parameterised top-level screen controller for the Pong video pipeline.
- Selects one of NUM_SCREENS pre-rendered video sources. Screen 0 is always the menu.
- Decodes menu clicks into navigation, level-cycle and theme-cycle actions.
- Switches screens only on a frame boundary to avoid tearing, and drives the shared colour theme to all renderers.

Parameters:
NUM_SCREENS, 4, number of video sources; screen 0 = menu; legal range 2..8
NUM_LEVELS, 2, number of difficulty levels; legal range 1..8
NUM_THEMES, 7, number of colour themes; legal range 1..8
COLOR_W, 12, RGB width per pixel
BTN_X0, 362, left edge of all menu buttons, inclusive
BTN_X1, 674, right edge of all menu buttons, inclusive
BTN_Y0, 46, top edge of button 0, inclusive
BTN_PITCH, 192, vertical distance between button tops
BTN_H, 100, button height; button k spans y in [BTN_Y0+k*BTN_PITCH, BTN_Y0+k*BTN_PITCH+BTN_H], inclusive
PALETTE, default below, packed NUM_THEMES x (fg,bg) pairs, COLOR_W bits each; theme t fg at bits [(2t+1)*COLOR_W-1 : 2t*COLOR_W], bg directly above it. Default pairs, theme 0..6: 000/FFF, 099/F66, 909/6F6, 990/66F, 339/FF6, 933/6FF, 393/F6F.

Ports:
clk  in  1  system/pixel clock
rst  in  1  synchronous, active-high reset
mouse_left  in  1  left mouse button level
xpos  in  12  mouse x
ypos  in  12  mouse y
back  in  1  return-to-menu request, level
vsync_in  in  1  raw frame vsync, used for the frame-boundary commit
src_rgb  in  NUM_SCREENS*COLOR_W  packed rgb per screen; screen s at [(s+1)*COLOR_W-1 : s*COLOR_W]
src_hsync  in  NUM_SCREENS  hsync per screen
src_vsync  in  NUM_SCREENS  vsync per screen
rgb_out  out  COLOR_W  registered selected rgb
hsync_out  out  1  registered selected hsync
vsync_out  out  1  registered selected vsync
screen  out  clog2(NUM_SCREENS)  committed screen index
level  out  clog2(max(NUM_LEVELS,2))  difficulty level
theme  out  clog2(max(NUM_THEMES,2))  theme index
color1  out  COLOR_W  palette fg of current theme
color2  out  COLOR_W  palette bg of current theme

Behaviour:
- Reset: screen=0, level=0, theme=0, pending cleared, rgb_out=0, hsync_out=0, vsync_out=0, edge-detect registers=0.
  - color1/color2 = PALETTE theme 0.
  - Reset mid-operation discards any pending switch.
- Click edge: click = mouse_left & ~mouse_left_q. Exactly one action per press; holding the button does nothing further.
- Hit test uses xpos/ypos in the click cycle. Only buttons 0..NUM_SCREENS exist. A click outside all buttons, or with screen!=0, is ignored.
- Button map:
  - Buttons k = 0..NUM_SCREENS-2: request screen k+1.
  - Button NUM_SCREENS-1: level cycle.
  - Button NUM_SCREENS: theme cycle.
- Level/theme cycle: applied the cycle after the click, only while screen==0. Value increments by 1 and wraps to 0 when the current value is N-1. When N==1, the value stays 0.
- color1/color2: combinational from the theme register, so they change with theme (1 cycle after the click).
- Navigation uses pending_valid and pending_idx:
  - Menu nav click sets pending_valid=1, pending_idx=k+1. A later request before commit overwrites pending_idx.
  - back=1 while screen!=0 sets pending_valid=1, pending_idx=0. back=1 while screen==0 is ignored.
- Commit: vs_rise = vsync_in & ~vsync_in_q. On vs_rise with pending_valid=1: screen<=pending_idx and pending_valid<=0.
- Simultaneous request and vs_rise:
  - The existing pending entry commits.
  - A same-cycle request stays pending for the next frame.
  - With no existing pending entry, the request is captured and commits on the following vs_rise.
- Output mux: rgb_out/hsync_out/vsync_out <= src_*[screen], one-cycle latency. The screen value used is the registered one, so the switch takes effect on the cycle after commit.
- No other state; level/theme persist across screen changes.

Test Plan:
- Reset then idle, default params -> screen=0, level=0, theme=0, color1=000, color2=FFF, rgb_out=src_rgb[11:0] one cycle after the source changes.
- Press at (400,100), screen 0; vsync_in rises 50 cycles later -> pending set, screen stays 0 until the vs_rise cycle, then screen=1; rgb_out follows src screen 1 one cycle later.
- Hold mouse_left 1000 cycles at (400,700), NUM_SCREENS=4, button 3 = level -> level 0->1 once only; second press -> wraps to 0.
- Seven separate presses at (400,814), theme button 4 -> theme 1,2,...,6,0; after press 1, color1=099 and color2=F66.
- On screen 2, back=1 -> screen unchanged until vs_rise, then screen=0; back=1 on screen 0 -> no change.
- Click on button 1 in the same cycle as vs_rise with an existing pending entry for screen 1 -> screen=1 at this vs_rise, screen=2 at the next; rst asserted while a request is pending -> no commit after reset.
